serial_logic_arbiter: RTL and testbench

Bit-serial controller that shares one 1-bit logic unit (the same AND/OR/NOR/XOR cell used elsewhere in the datapath) between two requesters. It grants one requester at a time, latches that requester's WIDTH-bit operands and 2-bit control, and steps the 1-bit cell across bit positions LSB-first, one bit per clock. It returns the assembled WIDTH-bit result with a one-cycle `done` pulse tagged with the requester id. Round-robin arbitration prevents either requester from starving the other.

---
 rtl/serial_logic_arbiter.sv | 104 ++++++++++
 tb/tb_serial_logic_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_logic_arbiter.sv
// Two-requester round-robin front end for a shared 1-bit AND/OR/NOR/XOR cell.
// Operands are latched at grant and evaluated LSB-first, one bit per clock.
module serial_logic_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [1:0]       control0,
  input  logic             req1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [1:0]       control1,
  output logic             busy,
  output logic             grant,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LASTCNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, stateNext;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [WIDTH-1:0] opA, opB, res, resNext;
  logic [1:0]       ctl;
  logic             anyReq, pick, bitVal, lastBit;

  // Arbitration, the single shared logic cell, and next-state decode.
  always_comb begin
    anyReq    = req0 | req1;
    pick      = (req0 && req1) ? ~last : req1;
    bitVal    = 1'b0;
    case (ctl)
      2'd0:    bitVal = opA[cnt] & opB[cnt];
      2'd1:    bitVal = opA[cnt] | opB[cnt];
      2'd2:    bitVal = ~(opA[cnt] | opB[cnt]);
      default: bitVal = opA[cnt] ^ opB[cnt];
    endcase
    resNext      = res;
    resNext[cnt] = bitVal;
    lastBit      = (cnt == LASTCNT);
    stateNext    = state;
    case (state)
      IDLE:    if (anyReq) stateNext = RUN;
      RUN:     if (lastBit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Operand capture at grant, bit-serial accumulation during RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      last    <= 1'b1;
      grant   <= 1'b0;
      done_id <= 1'b0;
      out     <= '0;
      opA     <= '0;
      opB     <= '0;
      ctl     <= '0;
      res     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            opA   <= pick ? A1 : A0;
            opB   <= pick ? B1 : B0;
            ctl   <= pick ? control1 : control0;
            grant <= pick;
            last  <= pick;
            cnt   <= '0;
            res   <= '0;
          end
        end
        RUN: begin
          res <= resNext;
          if (lastBit) begin
            out     <= resNext;
            done_id <= grant;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_logic_arbiter.sv
// Randomized self-checking bench for serial_logic_arbiter against a
// transaction-level model (whole-vector ops, round-robin pointer).
module tb_serial_logic_arbiter;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic [1:0]   control0 = '0, control1 = '0;
  logic         busy, grant, done, done_id;
  logic [W-1:0] out;

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic         lastModel = 1'b1;
  logic [W-1:0] outModel = '0;

  serial_logic_arbiter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .A0(A0), .B0(B0), .control0(control0),
    .req1(req1), .A1(A1), .B1(B1), .control1(control1),
    .busy(busy), .grant(grant), .done(done), .done_id(done_id), .out(out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] refOp(input logic [1:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (c)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [1:0] c0,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic [1:0] c1);
    req0 = r0; req1 = r1;
    A0 = a0; B0 = b0; control0 = c0;
    A1 = a1; B1 = b1; control1 = c1;
  endtask

  // One complete transaction starting from IDLE; pmode 1/2 disturbs inputs mid-run.
  task automatic runOp(input string tag, input int pmode, output int doneCyc);
    logic         expGrant;
    logic [W-1:0] expOut;
    expGrant = (req0 && req1) ? ~lastModel : req1;
    expOut   = expGrant ? refOp(control1, A1, B1) : refOp(control0, A0, B0);
    @(posedge clock); #1;
    lastModel = expGrant;
    checkOutput({tag, " grant"}, grant, expGrant);
    checkOutput({tag, " busy@grant"}, busy, 1);
    if (pmode == 1) begin
      A0 = '0;
      control0 = 2'd2;
    end else if (pmode == 2) begin
      A0 = W'($urandom); B0 = W'($urandom); control0 = 2'($urandom);
      A1 = W'($urandom); B1 = W'($urandom); control1 = 2'($urandom);
    end
    for (int i = 1; i < W; i++) begin
      @(posedge clock); #1;
      checkOutput({tag, " busy@run"}, busy, 1);
      checkOutput({tag, " done@run"}, done, 0);
      checkOutput({tag, " out held"}, out, outModel);
      checkOutput({tag, " grant held"}, grant, expGrant);
    end
    @(posedge clock); #1;
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " out"}, out, expOut);
    checkOutput({tag, " done_id"}, done_id, expGrant);
    checkOutput({tag, " busy@done"}, busy, 1);
    doneCyc  = cyc;
    outModel = expOut;
    @(posedge clock); #1;
    checkOutput({tag, " done after"}, done, 0);
    checkOutput({tag, " busy after"}, busy, 0);
    checkOutput({tag, " out after"}, out, expOut);
    checkOutput({tag, " done_id held"}, done_id, expGrant);
  endtask

  initial begin
    int           d, prevD, gap, r;
    logic [W-1:0] t2Exp [3];
    logic [W-1:0] ra0, rb0, ra1, rb1;
    logic [1:0]   rc0, rc1;
    t2Exp[0] = 8'hFC; t2Exp[1] = 8'h03; t2Exp[2] = 8'h3C;

    repeat (2) @(negedge clock);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset grant", grant, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset done_id", done_id, 0);
    checkOutput("reset out", out, 0);
    reset = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checkOutput("idle busy", busy, 0);
      checkOutput("idle done", done, 0);
      checkOutput("idle out", out, 0);
    end

    applyStimulus(1, 0, 8'hF0, 8'hCC, 2'd0, 0, 0, 2'd0);
    runOp("t1", 0, d);
    checkOutput("t1 const", out, 8'hC0);

    for (int c = 1; c < 4; c++) begin
      applyStimulus(1, 0, 8'hF0, 8'hCC, 2'(c), 0, 0, 2'd0);
      runOp("t2", 0, d);
      checkOutput("t2 const", out, 32'(t2Exp[c-1]));
    end
    applyStimulus(1, 0, 8'hFF, 8'h00, 2'd3, 0, 0, 2'd0);
    runOp("t2 xor", 0, d);
    checkOutput("t2 xor const", out, 8'hFF);

    // Both requesters held high from reset.
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1, 1, 8'hF0, 8'hCC, 2'd0, 8'hAA, 8'h55, 2'd3);
    @(negedge clock);
    reset = 1'b0;
    lastModel = 1'b1;
    outModel  = '0;
    prevD = 0;
    for (int k = 0; k < 4; k++) begin
      runOp("t3", 0, d);
      checkOutput("t3 rr order", done_id, 32'(k % 2));
      if (k % 2 == 1) checkOutput("t3 req1 out", out, 8'hFF);
      if (k > 0) checkOutput("t3 spacing", d - prevD, W + 2);
      prevD = d;
    end

    applyStimulus(1, 0, 8'h0F, 8'h0F, 2'd0, 0, 0, 2'd0);
    runOp("t4", 1, d);
    checkOutput("t4 const", out, 8'h0F);

    // Reset in the fourth RUN cycle.
    applyStimulus(1, 0, 8'h3C, 8'h5A, 2'd1, 0, 0, 2'd0);
    @(posedge clock); #1;
    repeat (3) begin
      @(posedge clock); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5 busy", busy, 0);
    checkOutput("t5 done", done, 0);
    checkOutput("t5 out", out, 0);
    checkOutput("t5 grant", grant, 0);
    checkOutput("t5 done_id", done_id, 0);
    @(negedge clock);
    reset = 1'b0;
    lastModel = 1'b1;
    outModel  = '0;
    applyStimulus(1, 0, 8'hA5, 8'h0F, 2'd3, 0, 0, 2'd0);
    runOp("t5 fresh", 0, d);
    checkOutput("t5 const", out, 8'hAA);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 3);
      req0 = 1'b0; req1 = 1'b0;
      repeat (gap) begin
        @(posedge clock); #1;
        checkOutput("rand idle busy", busy, 0);
        checkOutput("rand idle done", done, 0);
      end
      r   = $urandom_range(1, 3);
      ra0 = W'($urandom); rb0 = W'($urandom); rc0 = 2'($urandom);
      ra1 = W'($urandom); rb1 = W'($urandom); rc1 = 2'($urandom);
      applyStimulus(r[0], r[1], ra0, rb0, rc0, ra1, rb1, rc1);
      runOp("rand", ($urandom_range(0, 1) == 1) ? 2 : 0, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
